// File: rtl/pipelined_adder_nbit.sv
// Segmented carry pipeline adder/subtractor: each stage ripples one SEG-bit slice
// and registers its carry; operands and partial sums travel with the transaction.
module pipelined_adder_nbit #(
  parameter int NUM_BITS   = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  input  logic                sub,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int SEG = NUM_BITS / NUM_STAGES;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is low only while the last stage holds a result the consumer refuses.
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] carry_q, carry_d;
  logic [NUM_BITS-1:0]   opa_q [NUM_STAGES];
  logic [NUM_BITS-1:0]   opa_d [NUM_STAGES];
  logic [NUM_BITS-1:0]   opb_q [NUM_STAGES];
  logic [NUM_BITS-1:0]   opb_d [NUM_STAGES];
  logic [NUM_BITS-1:0]   sum_q [NUM_STAGES];
  logic [NUM_BITS-1:0]   sum_d [NUM_STAGES];

  logic                  stall;
  logic                  accept;
  logic [NUM_BITS-1:0]   src_a;
  logic [NUM_BITS-1:0]   src_b;
  logic [NUM_BITS-1:0]   src_s;
  logic                  src_c;
  logic                  src_v;
  logic [SEG:0]          seg_sum;

  assign stall     = valid_q[NUM_STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q[NUM_STAGES-1];
  assign sum       = sum_q[NUM_STAGES-1];
  assign overflow  = carry_q[NUM_STAGES-1];

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    src_a   = '0;
    src_b   = '0;
    src_s   = '0;
    src_c   = 1'b0;
    src_v   = 1'b0;
    seg_sum = '0;
    if (!stall) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (k == 0) begin
          // Subtraction is A + ~B + 1; bubbles enter with zeroed data.
          src_v = accept;
          src_a = accept ? a : '0;
          src_b = accept ? (sub ? ~b : b) : '0;
          src_c = accept & (sub | carry_in);
          src_s = '0;
        end else begin
          src_v = valid_q[(k > 0) ? k-1 : 0];
          src_a = opa_q[(k > 0) ? k-1 : 0];
          src_b = opb_q[(k > 0) ? k-1 : 0];
          src_c = carry_q[(k > 0) ? k-1 : 0];
          src_s = sum_q[(k > 0) ? k-1 : 0];
        end
        seg_sum = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
                + {{SEG{1'b0}}, src_c};
        valid_d[k]                = src_v;
        opa_d[k]                  = src_a;
        opb_d[k]                  = src_b;
        sum_d[k]                  = src_s;
        sum_d[k][k*SEG +: SEG]    = seg_sum[SEG-1:0];
        carry_d[k]                = seg_sum[SEG];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (n_rst && in_valid) begin
      if ($isunknown(a)) $error("pipelined_adder_nbit: input a has non-0/1 bits");
      if ($isunknown(b)) $error("pipelined_adder_nbit: input b has non-0/1 bits");
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench for pipelined_adder_nbit (16 bits, 4 stages): directed vectors
// with hand-computed results, reset flush, stall hold and a random handshake soak.
module tb_pipelined_adder_nbit;

  localparam int W = 16;

  // clock / reset
  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         overflow;
  logic         out_valid;
  logic         out_ready = 1'b1;

  pipelined_adder_nbit #(.NUM_BITS(W), .NUM_STAGES(4)) dut (
    .clk(clk), .n_rst(n_rst), .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // scoreboard state
  logic [W:0]   exp_q[$];
  logic [W:0]   drv_exp = '0;
  logic [W:0]   exp_v;
  int           total = 0;
  int           bad = 0;
  int           n_out = 0;
  int           run_len = 0;
  int           max_run = 0;
  bit           rnd_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    if (ms) return {1'b0, ma} + {1'b0, ~mb} + 17'd1;
    return {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
  endfunction

  // monitor: compare delivered results first, then record this cycle's acceptance
  always @(negedge clk) begin
    if (!n_rst) begin
      exp_q.delete();
      run_len = 0;
    end else begin
      if (out_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", {overflow, sum}, 64'h1_dead);
        else begin
          exp_v = exp_q.pop_front();
          check("result", {overflow, sum}, exp_v);
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
    end
  end

  // driver: called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic ts, input logic [W:0] texp, output int waited);
    a = ta; b = tb; carry_in = tc; sub = ts; drv_exp = texp; in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        check("send_timeout", 64'(waited), 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int guard;
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 0);
  endtask

  initial begin
    int w;
    int base;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    // reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_sum", 64'(sum), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // carry through every segment, exact 4-cycle latency
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, w);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("latency_early", 64'(out_valid), 0);
    end
    @(negedge clk);
    check("latency_at4", 64'(out_valid), 1);
    @(posedge clk); #1;

    // subtraction with and without borrow, plus assorted additions
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0_FFFE, w);
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h1_0002, w);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h1_0000, w);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 17'h0_5556, w);
    send(16'h0FFF, 16'h0001, 1'b0, 1'b0, 17'h0_1000, w);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 17'h1_0000, w);
    drain();

    // 8 back-to-back transactions, no stalls, 8 consecutive results
    max_run = 0;
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      send(16'(i), 16'h00FF, 1'b1, 1'b0, 17'(i + 16'h0100), w);
      check("b2b_in_ready_wait", 64'(w), 0);
    end
    drain();
    check("b2b_consecutive", 64'(max_run), 8);
    check("b2b_count", 64'(n_out - base), 8);

    // fill pipe with consumer stalled, hold, then drain
    base = n_out;
    out_ready = 1'b0;
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 17'h0_0300, w);
    send(16'h1111, 16'h2222, 1'b1, 1'b0, 17'h0_3334, w);
    send(16'hF000, 16'h1000, 1'b0, 1'b0, 17'h1_0000, w);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h0_0100, w);
    a = 16'h0003; b = 16'h0001; carry_in = 1'b0; sub = 1'b1; drv_exp = 17'h1_0002;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 0);
      check("stall_sum", {overflow, sum}, 17'h0_0300);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drain();
    check("stall_count", 64'(n_out - base), 5);

    // reset with 3 in flight: nothing may emerge afterwards
    base = n_out;
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 17'h0_0002, w);
    send(16'h0002, 16'h0002, 1'b0, 1'b0, 17'h0_0004, w);
    send(16'h0003, 16'h0003, 1'b0, 1'b0, 17'h0_0006, w);
    in_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_in_ready", 64'(in_ready), 1);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("postrst_idle", {out_valid, overflow, sum}, 18'h0);
    end
    check("postrst_count", 64'(n_out - base), 0);
    @(posedge clk); #1;

    // random soak with random valid gaps and consumer back-pressure
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          ra = 16'($urandom_range(0, 16'hFFFF));
          rb = 16'($urandom_range(0, 16'hFFFF));
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_nbit.md
PIPELINED_ADDER_NBIT -- requirements
Module: pipelined_adder_nbit

Interface
REQ-001 Parameter NUM_BITS, default 16: operand and sum width; legal values 4..64.
REQ-002 Parameter NUM_STAGES, default 4: pipeline depth in carry segments; legal values 1..NUM_BITS, and NUM_BITS % NUM_STAGES == 0.
REQ-003 Port clk  input  1: single clock, rising-edge.
REQ-004 Port n_rst  input  1: asynchronous, active-low reset.
REQ-005 Port a  input  NUM_BITS: operand A, unsigned.
REQ-006 Port b  input  NUM_BITS: operand B, unsigned.
REQ-007 Port carry_in  input  1: carry into bit 0; used only when sub=0.
REQ-008 Port sub  input  1: 0 = A+B+carry_in; 1 = A-B.
REQ-009 Port in_valid  input  1: a, b, carry_in and sub are valid this cycle.
REQ-010 Port in_ready  output  1: the block accepts the input this cycle.
REQ-011 Port sum  output  NUM_BITS: result, low NUM_BITS bits.
REQ-012 Port overflow  output  1: carry out of the MSB.
REQ-013 Port out_valid  output  1: sum and overflow are valid.
REQ-014 Port out_ready  input  1: the consumer accepts the result this cycle.

Function
REQ-015 Define SEG = NUM_BITS/NUM_STAGES; stage k adds bits [k*SEG +: SEG] using the carry registered by stage k-1 (ripple within a segment, registered between segments).
REQ-016 When sub=1, the effective operand is ~b and the effective carry-in is 1; carry_in is ignored.
REQ-017 Result = low NUM_BITS bits of A + B_eff + cin_eff; overflow = bit NUM_BITS of that sum, so overflow=1 on sub means no borrow.
REQ-018 Not-yet-added operand slices and finished sum slices travel with their transaction through every stage register; operands are captured once at acceptance.
REQ-019 Each stage holds one valid flag; the result appears NUM_STAGES cycles after acceptance when there is no stall.
REQ-020 Stall condition: stall = out_valid & ~out_ready.
REQ-021 in_ready SHALL equal ~stall, computed combinationally.
REQ-022 Acceptance occurs on a rising edge where in_valid & in_ready are both 1.
REQ-023 When stall=1, every stage register and valid flag holds its value, and sum/overflow hold stable.
REQ-024 When stall=0, all stages advance one position, and stage 0 loads the new transaction if one is accepted, otherwise a bubble (valid=0).
REQ-025 Bubbles are not collapsed, and throughput is one result per cycle with out_ready held high.
REQ-026 Transaction order is preserved, with no loss or duplication under any in_valid/out_ready pattern.
REQ-027 With NUM_STAGES=1, the block is a registered adder with 1-cycle latency and the same handshake.
REQ-028 In simulation only, any a or b bit that is not 0/1 while in_valid=1 raises $error, naming the input.

Reset
REQ-029 While n_rst=0, all valid flags are 0, out_valid=0, sum=0, overflow=0, and all stage data is 0; in_ready=1, because it is combinational from out_valid.
REQ-030 Reset asserted mid-operation discards every in-flight transaction immediately, with no result emitted after release.
REQ-031 The first acceptance is possible on the first rising edge after n_rst deasserts.

Verification (NUM_BITS=16, NUM_STAGES=4)
REQ-032 Accept a=0xFFFF, b=0x0001, carry_in=0, sub=0 with out_ready=1 -> out_valid exactly 4 cycles later, sum=0x0000, overflow=1.
REQ-033 Accept a=0x0005, b=0x0007, sub=1, carry_in=1 -> sum=0xFFFE, overflow=0; then accept a=0x0007, b=0x0005, sub=1 -> sum=0x0002, overflow=1.
REQ-034 Send 8 back-to-back transactions (a=i, b=0x00FF, carry_in=1) with out_ready=1 -> 8 consecutive out_valid cycles, sum=i+0x0100 in order, in_ready constantly 1.
REQ-035 Hold out_ready=0 with the pipe full -> in_ready=0 and sum stable for 5 cycles, with no new acceptance; after out_ready=1, results drain in order with none lost.
REQ-036 Assert n_rst=0 with 3 transactions in flight, release it, and wait 6 cycles -> out_valid stays 0, sum=0, overflow=0.
REQ-037 Random a/b/sub/carry_in with random in_valid/out_ready over 10k cycles -> every result matches the reference model (A+B+cin or A-B), in order, with correct overflow.
